// File: rtl/iter_alu_exu_if.sv
// ----------------------------------------------------------------------------
// iter_alu_exu_if : request/response channel bundle for iter_alu_exu
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface iter_alu_exu_if #(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 5
);
  logic              req_vld;
  logic              req_rdy;
  logic [3:0]        req_op;
  logic [GPR_AW-1:0] req_rs1;
  logic [GPR_AW-1:0] req_rs2;
  logic [XLEN-1:0]   req_imm;
  logic              req_use_imm;
  logic [GPR_AW-1:0] req_rd;

  logic              rsp_vld;
  logic              rsp_rdy;
  logic [GPR_AW-1:0] rsp_rd;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;

  modport master (
    output req_vld, req_op, req_rs1, req_rs2, req_imm, req_use_imm, req_rd, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rd, rsp_data, rsp_err
  );

  modport slave (
    input  req_vld, req_op, req_rs1, req_rs2, req_imm, req_use_imm, req_rd, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rd, rsp_data, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/iter_alu_exu.sv
// ----------------------------------------------------------------------------
// iter_alu_exu : ALU execute unit with private GPR file and iterative shifter
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module iter_alu_exu #(
  parameter int XLEN       = 32,
  parameter int GPR_AW     = 5,
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  iter_alu_exu_if.slave     bus,
  input  logic [GPR_AW-1:0] dbg_raddr,
  output logic [XLEN-1:0]   dbg_rdata
);

  localparam int NREG    = 2 ** GPR_AW;
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int STEP_W  = $clog2(SHIFT_STEP + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t             state;
  logic [XLEN-1:0]    gpr [NREG];
  logic [XLEN-1:0]    res_data;
  logic [GPR_AW-1:0]  res_rd;
  logic               res_err;
  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] rem;
  logic [1:0]         sh_kind;

  logic               req_hsk;
  logic               rsp_hsk;
  logic               fwd1;
  logic               fwd2;
  logic [XLEN-1:0]    src1;
  logic [XLEN-1:0]    src2;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_res;
  logic               alu_err;
  logic               is_shift;
  logic [1:0]         new_kind;
  logic [STEP_W-1:0]  step;
  logic [XLEN-1:0]    acc_nxt;
  logic [SHAMT_W-1:0] rem_nxt;

  assign bus.req_rdy  = (state == S_IDLE) | ((state == S_RESP) & bus.rsp_rdy);
  assign bus.rsp_vld  = (state == S_RESP);
  assign bus.rsp_rd   = res_rd;
  assign bus.rsp_data = res_data;
  assign bus.rsp_err  = res_err;

  assign req_hsk = bus.req_vld & bus.req_rdy;
  assign rsp_hsk = bus.rsp_vld & bus.rsp_rdy;

  assign dbg_rdata = (dbg_raddr == '0) ? '0 : gpr[dbg_raddr];

  // A request accepted in RESP sees the result retiring in the same cycle.
  assign fwd1 = (state == S_RESP) && (bus.req_rs1 == res_rd) && (res_rd != '0);
  assign fwd2 = (state == S_RESP) && (bus.req_rs2 == res_rd) && (res_rd != '0);

  always_comb begin
    src1 = '0;
    src2 = '0;
    if (fwd1) begin
      src1 = res_data;
    end else if (bus.req_rs1 != '0) begin
      src1 = gpr[bus.req_rs1];
    end
    if (bus.req_use_imm) begin
      src2 = bus.req_imm;
    end else if (fwd2) begin
      src2 = res_data;
    end else if (bus.req_rs2 != '0) begin
      src2 = gpr[bus.req_rs2];
    end
  end

  assign shamt = src2[SHAMT_W-1:0];

  always_comb begin
    alu_res  = '0;
    alu_err  = 1'b0;
    is_shift = 1'b0;
    new_kind = SH_SLL;
    case (bus.req_op)
      OP_ADD:  alu_res = src1 + src2;
      OP_SUB:  alu_res = src1 - src2;
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      OP_SLL: begin
        is_shift = 1'b1;
        new_kind = SH_SLL;
      end
      OP_SRL: begin
        is_shift = 1'b1;
        new_kind = SH_SRL;
      end
      OP_SRA: begin
        is_shift = 1'b1;
        new_kind = SH_SRA;
      end
      default: alu_err = 1'b1;
    endcase
  end

  // Per-cycle shift distance is bounded by SHIFT_STEP, keeping the shifter narrow.
  always_comb begin
    step = '0;
    if (int'(rem) < SHIFT_STEP) begin
      step = STEP_W'(rem);
    end else begin
      step = STEP_W'(SHIFT_STEP);
    end
    case (sh_kind)
      SH_SLL:  acc_nxt = acc << step;
      SH_SRL:  acc_nxt = acc >> step;
      default: acc_nxt = $unsigned($signed(acc) >>> step);
    endcase
    rem_nxt = rem - SHAMT_W'(step);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      res_data <= '0;
      res_rd   <= '0;
      res_err  <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      sh_kind  <= SH_SLL;
      for (int i = 0; i < NREG; i++) begin
        gpr[i] <= '0;
      end
    end else begin
      if (rsp_hsk && !res_err && (res_rd != '0)) begin
        gpr[res_rd] <= res_data;
      end

      case (state)
        S_IDLE, S_RESP: begin
          if (req_hsk) begin
            res_rd <= bus.req_rd;
            if (alu_err) begin
              res_data <= '0;
              res_err  <= 1'b1;
              state    <= S_RESP;
            end else if (is_shift) begin
              res_err <= 1'b0;
              acc     <= src1;
              rem     <= shamt;
              sh_kind <= new_kind;
              if (shamt == '0) begin
                res_data <= src1;
                state    <= S_RESP;
              end else begin
                state <= S_SHIFT;
              end
            end else begin
              res_data <= alu_res;
              res_err  <= 1'b0;
              state    <= S_RESP;
            end
          end else if (rsp_hsk) begin
            state <= S_IDLE;
          end
        end

        S_SHIFT: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          if (rem_nxt == '0) begin
            res_data <= acc_nxt;
            state    <= S_RESP;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/iter_alu_exu.md
# iter_alu_exu

Parametrised successor to the single-cycle execute datapath. It owns a private general-purpose register file and accepts one ALU instruction at a time over a valid/ready request channel. Logic and add-class ops complete in one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle, so a large XLEN does not need a full barrel shifter. Each result is returned on a valid/ready response channel and written back to the register file on the response handshake; back-to-back dependent instructions are forwarded.

## Interface
- XLEN, 32: datapath width; power of two, ≥ 8.
- GPR_AW, 5: register address width; 2**GPR_AW registers, register 0 reads as zero.
- SHIFT_STEP, 1: bits shifted per iteration cycle; power of two, 1 ≤ SHIFT_STEP ≤ XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10–15 illegal.
- req_rs1  in  GPR_AW  source-1 register.
- req_rs2  in  GPR_AW  source-2 register; ignored when req_use_imm = 1.
- req_imm  in  XLEN  immediate used as src2 when req_use_imm = 1.
- req_use_imm  in  1  select immediate as src2.
- req_rd  in  GPR_AW  destination register.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  response ready.
- rsp_rd  out  GPR_AW  destination of the held result.
- rsp_data  out  XLEN  result.
- rsp_err  out  1  illegal opcode flag.
- dbg_raddr  in  GPR_AW  debug read address.
- dbg_rdata  out  XLEN  combinational register read; 0 when dbg_raddr = 0.

## Operation
- States: IDLE, SHIFT, RESP.
- Handshakes: request hsk = req_vld & req_rdy; response hsk = rsp_vld & rsp_rdy. req_rdy = (state == IDLE) | (state == RESP & rsp_rdy).
- Source operands on request hsk:
  - src1 = GPR[rs1]; src2 = req_use_imm ? req_imm : GPR[rs2].
  - Forwarding: if hsk happens in RESP and rsN == rsp_rd ≠ 0, srcN = rsp_data.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, SLTU):
  - Result registered into rsp_data; next state RESP.
  - ADD/SUB wrap modulo 2**XLEN.
  - SLT/SLTU return 1 or 0 zero-extended; SLT compares signed, SLTU unsigned.
- Shift ops (SLL, SRL, SRA):
  - shamt = src2[log2(XLEN)-1:0]; upper src2 bits are ignored. Load acc = src1 and rem = shamt.
  - If shamt = 0, next state RESP with rsp_data = src1. Otherwise next state SHIFT.
- SHIFT state, each cycle:
  - Shift acc by s = min(rem, SHIFT_STEP); rem -= s.
  - SLL fills with zeros; SRL with zeros; SRA replicates the original sign bit.
  - When rem reaches 0, rsp_data = shifted acc and next state RESP.
- Illegal op: rsp_data = 0, rsp_err = 1, next state RESP. No writeback on its response.
- RESP state:
  - rsp_vld = 1; rsp_rd, rsp_data and rsp_err are held stable until response hsk.
  - On response hsk: if rsp_err = 0 and rsp_rd ≠ 0, GPR[rsp_rd] = rsp_data.
  - Next state after response hsk: the new op's state if a request hsk happens in the same cycle, else IDLE.
  - Without response hsk: stay in RESP.
- GPR[0] is never written; writes to rd = 0 are dropped silently.

## Timing
- Reset values:
  - State IDLE, so req_rdy = 1.
  - rsp_vld = 0, rsp_data = 0, rsp_rd = 0, rsp_err = 0.
  - All GPRs = 0; acc and rem = 0.
- Latency, with request hsk at edge T:
  - Single-cycle op or shamt = 0: rsp_vld is high from T+1.
  - Shift: rsp_vld is high from T+1+ceil(shamt/SHIFT_STEP).
- Throughput: one single-cycle op per cycle with rsp_rdy tied high, using forwarding.
- Backpressure: rsp_rdy = 0 holds RESP indefinitely, and req_rdy stays 0 meanwhile.
- Writeback is visible on dbg_rdata the cycle after response hsk.
- Reset asserted mid-SHIFT or mid-RESP: the op is aborted with no writeback, and all outputs return to reset values asynchronously.

## Test plan
- Reset; ADD with GPR[1] = 5 (rs1 = 1), req_use_imm = 1, imm = 7, rd = 2; rsp_rdy = 1 → rsp_vld at T+1, rsp_data = 12; then dbg_raddr = 2 → 12.
- SUB 0 − 1 into rd = 3 → rsp_data = 0xFFFFFFFF. Same op with rd = 0 → dbg_rdata(0) stays 0.
- SRA of 0x80000000 by 31, SHIFT_STEP = 1 → rsp_vld at T+32, rsp_data = 0xFFFFFFFF. With SHIFT_STEP = 4 → rsp_vld at T+9, same data.
- Back-to-back ADD r1 = r0 + 3, then ADD r2 = r1 + r1, rsp_rdy = 1 → second rsp_data = 6 (forwarded); dbg r2 = 6.
- rsp_rdy = 0 for 5 cycles during RESP → rsp_vld, rsp_data and rsp_rd stable, req_rdy = 0. Then op = 12 → rsp_err = 1, rsp_data = 0, no write.
- Assert rst during an SLL by 20 (SHIFT_STEP = 1) → rsp_vld never rises; rd unchanged; req_rdy = 1 after release.
